// File: rtl/seq_stage_ctrl_if.sv
// seq_stage_ctrl_if: handshake and strobe bundle between the SEQ sequencer and its datapath/memories.
//   run, imem_ack/err, icode_in, Cnd, dmem_ack/err     -> sequencer inputs
//   imem_req, dmem_req/we, ir/cc/rf/pc strobes          <- sequencer outputs
//   stat, state, retired                                <- sequencer status
interface seq_stage_ctrl_if #(parameter int CNT_W = 32);
  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic             imem_err;
  logic [3:0]       icode_in;
  logic             Cnd;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             dmem_err;
  logic             ir_we;
  logic             cc_we;
  logic             rf_we_e;
  logic             rf_we_m;
  logic             pc_we;
  logic [2:0]       stat;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  modport slave (
    input  run, imem_ack, imem_err, icode_in, Cnd, dmem_ack, dmem_err,
    output imem_req, dmem_req, dmem_we, ir_we, cc_we, rf_we_e, rf_we_m, pc_we, stat, state, retired
  );
  modport master (
    output run, imem_ack, imem_err, icode_in, Cnd, dmem_ack, dmem_err,
    input  imem_req, dmem_req, dmem_we, ir_we, cc_we, rf_we_e, rf_we_m, pc_we, stat, state, retired
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle Y86 SEQ sequencer (FETCH..PCU) with memory handshakes, status and retired count.
//   CLK, RST_N : clock and asynchronous active-low reset
//   bus        : seq_stage_ctrl_if.slave carrying handshakes, write strobes, stat, state, retired
module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  seq_stage_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DEC, EXE, MEM, WB, PCU, STOP} state_t;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       icode_q, icode_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             waiting, ack, timeout, mem_op, fetch_bad;
  // A cycle counts toward the timeout only while a request is actually outstanding.
  assign waiting   = (state_q == FETCH && bus.run) || state_q == MEM;
  assign ack       = state_q == FETCH ? bus.imem_ack : bus.dmem_ack;
  // Fires on the MEM_TIMEOUT-th unanswered request cycle; an ack that same cycle wins.
  assign timeout   = waiting && !ack && wait_q == WAIT_LAST;
  assign mem_op    = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign fetch_bad = bus.imem_err || bus.icode_in > 4'hB || bus.icode_in == 4'h0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q   <= FETCH;
      stat_q    <= AOK;
      retired_q <= '0;
      icode_q   <= 4'h1;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      icode_q   <= icode_d;
      wait_q    <= wait_d;
    end
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    icode_d   = icode_q;
    case (state_q)
      FETCH: if (waiting && ack) begin
        stat_d  = bus.imem_err ? ADR : bus.icode_in > 4'hB ? INS : bus.icode_in == 4'h0 ? HLT : AOK;
        state_d = fetch_bad ? STOP : DEC;
        icode_d = fetch_bad ? icode_q : bus.icode_in;
      end
      DEC:   state_d = EXE;
      EXE:   state_d = mem_op ? MEM : WB;
      MEM:   if (ack) begin
        stat_d  = bus.dmem_err ? ADR : stat_q;
        state_d = bus.dmem_err ? STOP : WB;
      end
      WB:    state_d = PCU;
      PCU: begin
        retired_d = retired_q + 1'b1;
        state_d   = FETCH;
      end
      default: state_d = state_q;
    endcase
    if (timeout) begin
      stat_d  = ADR;
      state_d = STOP;
    end
    // While run is low in FETCH nothing is outstanding, so the count simply holds.
    wait_d = (state_d != state_q || (waiting && ack)) ? '0 : waiting ? wait_q + 1'b1 : wait_q;
  end
  assign bus.imem_req = state_q == FETCH && bus.run;
  assign bus.dmem_req = state_q == MEM;
  assign bus.dmem_we  = state_q == MEM && icode_q inside {4'h4, 4'h8, 4'hA};
  assign bus.ir_we    = state_q == FETCH && bus.imem_ack;
  assign bus.cc_we    = state_q == EXE && icode_q == 4'h6;
  assign bus.rf_we_e  = state_q == WB && (icode_q inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB} || (icode_q == 4'h2 && bus.Cnd));
  assign bus.rf_we_m  = state_q == WB && icode_q inside {4'h5, 4'hB};
  assign bus.pc_we    = state_q == PCU;
  assign bus.stat     = stat_q;
  assign bus.state    = state_q;
  assign bus.retired  = retired_q;
endmodule
